// File: rtl/host_mem_responder_if.sv
// ---------------------------------------------------------------------------
// host_mem_responder_if
// Purpose : groups the host-side read/write handshake between the kernel
//           wrapper (requester) and the memory responder.
// Signals :
//   read_enable / read_addr / finish_read  requester read burst control
//   read_ready / read_data                 responder read beat answer
//   write_enable / write_addr / write_data / finish_write
//                                          requester write burst control
//   write_ready                            responder write beat answer
//   done                                   requester completion flag
// Modports: master = requester side, slave = responder side.
// ---------------------------------------------------------------------------
interface host_mem_responder_if;

   logic        read_enable;
   logic [63:0] read_addr;
   logic        finish_read;
   logic [63:0] read_ready;
   logic [31:0] read_data;

   logic        write_enable;
   logic [63:0] write_addr;
   logic [31:0] write_data;
   logic        finish_write;
   logic [63:0] write_ready;

   logic        done;

   modport master (
      output read_enable, read_addr, finish_read,
      output write_enable, write_addr, write_data, finish_write,
      output done,
      input  read_ready, read_data, write_ready
   );

   modport slave (
      input  read_enable, read_addr, finish_read,
      input  write_enable, write_addr, write_data, finish_write,
      input  done,
      output read_ready, read_data, write_ready
   );

endinterface

// File: rtl/host_mem_responder.sv
// ---------------------------------------------------------------------------
// host_mem_responder
// Purpose : memory model answering the kernel wrapper's word-by-word host
//           handshake. Reads are served from an internal 32-bit word array
//           after RD_LAT cycles, writes are absorbed into the same array
//           after WR_LAT cycles. Out-of-range accesses return BAD_DATA or
//           are dropped, and are counted.
// Ports   :
//   clk        clock
//   reset      asynchronous active-low reset
//   bus        host handshake (slave side of host_mem_responder_if)
//   load_en    preload strobe, honoured only while idle
//   load_addr  preload word index
//   load_data  preload data
//   rd_beats   read beats served since reset (wraps)
//   wr_beats   write beats committed since reset (wraps)
//   err_cnt    out-of-range accesses since reset (saturates)
//   done_seen  sticky flag, set once done has been seen high
// ---------------------------------------------------------------------------
module host_mem_responder #(
   parameter int unsigned ADDR_WID = 14,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned WR_LAT   = 1,
   parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
   input  logic                 clk,
   input  logic                 reset,
   host_mem_responder_if.slave  bus,
   input  logic                 load_en,
   input  logic [ADDR_WID-1:0]  load_addr,
   input  logic [31:0]          load_data,
   output logic [31:0]          rd_beats,
   output logic [31:0]          wr_beats,
   output logic [15:0]          err_cnt,
   output logic                 done_seen
);

   localparam int unsigned DEPTH   = 2**ADDR_WID;
   localparam logic [3:0]  RD_LOAD = 4'(RD_LAT - 1);
   localparam logic [3:0]  WR_LOAD = 4'(WR_LAT - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_HOLD,
      WR_WAIT,
      WR_HOLD
   } state_t;

   state_t              r_state;
   state_t              w_nextState;

   logic [3:0]          r_latCnt;
   logic [ADDR_WID-1:0] r_rdIdx;
   logic                r_rdBad;
   logic                r_wrFirst;
   logic [31:0]         r_mem [DEPTH];

   logic                r_readReady;
   logic                r_writeReady;
   logic [31:0]         r_readData;
   logic [31:0]         r_rdBeats;
   logic [31:0]         r_wrBeats;
   logic [15:0]         r_errCnt;
   logic                r_doneSeen;

   logic                w_rdAccept;
   logic                w_wrAccept;
   logic                w_rdFire;
   logic                w_wrFire;
   logic                w_wrCommit;
   logic                w_preload;
   logic                w_rdAddrBad;
   logic                w_wrAddrBad;
   logic                w_errInc;
   logic [ADDR_WID-1:0] w_rdIdxIn;
   logic [ADDR_WID-1:0] w_wrIdx;

   // A byte address is usable only if it is word aligned and every bit above
   // the word index is zero; anything else is treated as out of range.
   function automatic logic addrBad(input logic [63:0] addr);
      return (addr[63:ADDR_WID+2] != '0) || (addr[1:0] != 2'b00);
   endfunction

   assign w_rdAddrBad = addrBad(bus.read_addr);
   assign w_wrAddrBad = addrBad(bus.write_addr);
   assign w_rdIdxIn   = bus.read_addr[ADDR_WID+1:2];
   assign w_wrIdx     = bus.write_addr[ADDR_WID+1:2];
   assign w_errInc    = (w_rdFire && r_rdBad) || (w_wrCommit && w_wrAddrBad);

   // State register. Reset drops any burst in flight so no late ready pulse
   // can appear after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and strobe decode. Reads win over writes from idle, and a
   // dropped enable always beats a finish pulse or a pending latency expiry.
   // The write commit strobe only fires in the first WR_HOLD cycle, which is
   // the cycle in which write_ready is high and the requester holds its beat.
   always_comb begin
      w_nextState = r_state;
      w_rdAccept  = 1'b0;
      w_wrAccept  = 1'b0;
      w_rdFire    = 1'b0;
      w_wrFire    = 1'b0;
      w_wrCommit  = 1'b0;
      w_preload   = 1'b0;
      case (r_state)
         IDLE: begin
            w_preload = load_en;
            if (bus.read_enable) begin
               w_rdAccept  = 1'b1;
               w_nextState = RD_WAIT;
            end else if (bus.write_enable) begin
               w_wrAccept  = 1'b1;
               w_nextState = WR_WAIT;
            end
         end
         RD_WAIT: begin
            if (!bus.read_enable) begin
               w_nextState = IDLE;
            end else if (r_latCnt == 4'd0) begin
               w_rdFire    = 1'b1;
               w_nextState = RD_HOLD;
            end
         end
         RD_HOLD: begin
            if (!bus.read_enable) begin
               w_nextState = IDLE;
            end else if (bus.finish_read) begin
               w_rdAccept  = 1'b1;
               w_nextState = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (!bus.write_enable) begin
               w_nextState = IDLE;
            end else if (r_latCnt == 4'd0) begin
               w_wrFire    = 1'b1;
               w_nextState = WR_HOLD;
            end
         end
         WR_HOLD: begin
            w_wrCommit = r_wrFirst;
            if (!bus.write_enable) begin
               w_nextState = IDLE;
            end else if (bus.finish_write) begin
               w_wrAccept  = 1'b1;
               w_nextState = WR_WAIT;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Latency counter and read address latch. The counter is loaded with
   // LAT-1 on accept so that the ready pulse lands exactly LAT edges after
   // the accepting edge. The read address is captured at accept so later
   // changes on read_addr cannot affect the beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_latCnt  <= 4'd0;
         r_rdIdx   <= '0;
         r_rdBad   <= 1'b0;
         r_wrFirst <= 1'b0;
      end else begin
         if (w_rdAccept) begin
            r_latCnt <= RD_LOAD;
            r_rdIdx  <= w_rdIdxIn;
            r_rdBad  <= w_rdAddrBad;
         end else if (w_wrAccept) begin
            r_latCnt <= WR_LOAD;
         end else if (r_latCnt != 4'd0) begin
            r_latCnt <= r_latCnt - 4'd1;
         end
         r_wrFirst <= w_wrFire;
      end
   end

   // Handshake outputs and statistics. Ready flags are single-cycle pulses;
   // read_data keeps its last value between pulses. err_cnt sticks at its
   // maximum instead of wrapping so heavy error traffic stays visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_readReady  <= 1'b0;
         r_writeReady <= 1'b0;
         r_readData   <= 32'd0;
         r_rdBeats    <= 32'd0;
         r_wrBeats    <= 32'd0;
         r_errCnt     <= 16'd0;
         r_doneSeen   <= 1'b0;
      end else begin
         r_readReady  <= w_rdFire;
         r_writeReady <= w_wrFire;
         if (w_rdFire) begin
            r_readData <= r_rdBad ? BAD_DATA : r_mem[r_rdIdx];
            r_rdBeats  <= r_rdBeats + 32'd1;
         end
         if (w_wrCommit) begin
            r_wrBeats <= r_wrBeats + 32'd1;
         end
         if (w_errInc && (r_errCnt != 16'hFFFF)) begin
            r_errCnt <= r_errCnt + 16'd1;
         end
         if (bus.done) begin
            r_doneSeen <= 1'b1;
         end
      end
   end

   // Word array. It has no reset so preloaded contents survive a reset.
   // Preload and write commit live in different states and never collide.
   always_ff @(posedge clk) begin
      if (w_preload) begin
         r_mem[load_addr] <= load_data;
      end else if (w_wrCommit && !w_wrAddrBad) begin
         r_mem[w_wrIdx] <= bus.write_data;
      end
   end

   assign bus.read_ready  = {63'd0, r_readReady};
   assign bus.write_ready = {63'd0, r_writeReady};
   assign bus.read_data   = r_readData;
   assign rd_beats        = r_rdBeats;
   assign wr_beats        = r_wrBeats;
   assign err_cnt         = r_errCnt;
   assign done_seen       = r_doneSeen;

endmodule

// File: tb/tb_host_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_host_mem_responder
// Purpose : self-checking bench for host_mem_responder. Instance A uses the
//           default latencies (RD_LAT=2, WR_LAT=1); instance B uses RD_LAT=4
//           and exercises reset in the middle of a read wait.
//           Expected data comes from a word-level memory model indexed by
//           word number, plus simple beat/error tallies.
// ---------------------------------------------------------------------------
module tb_host_mem_responder;

   localparam int AW       = 14;
   localparam int A_RD_LAT = 2;
   localparam int A_WR_LAT = 1;
   localparam int B_RD_LAT = 4;
   localparam logic [31:0] BAD = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          resetA = 1'b1;
   logic          resetB = 1'b1;

   logic          loadEnA, loadEnB;
   logic [AW-1:0] loadAddrA, loadAddrB;
   logic [31:0]   loadDataA, loadDataB;
   logic [31:0]   rdBeatsA, wrBeatsA, rdBeatsB, wrBeatsB;
   logic [15:0]   errCntA, errCntB;
   logic          doneSeenA, doneSeenB;

   host_mem_responder_if busA ();
   host_mem_responder_if busB ();

   int checks = 0;
   int errors = 0;

   logic [31:0] refMem [int];
   int unsigned expRd = 0;
   int unsigned expWr = 0;
   int          expErr = 0;
   int          written [$];

   host_mem_responder #(
      .ADDR_WID (AW),
      .RD_LAT   (A_RD_LAT),
      .WR_LAT   (A_WR_LAT),
      .BAD_DATA (BAD)
   ) dutA (
      .clk       (clk),
      .reset     (resetA),
      .bus       (busA.slave),
      .load_en   (loadEnA),
      .load_addr (loadAddrA),
      .load_data (loadDataA),
      .rd_beats  (rdBeatsA),
      .wr_beats  (wrBeatsA),
      .err_cnt   (errCntA),
      .done_seen (doneSeenA)
   );

   host_mem_responder #(
      .ADDR_WID (AW),
      .RD_LAT   (B_RD_LAT),
      .WR_LAT   (A_WR_LAT),
      .BAD_DATA (BAD)
   ) dutB (
      .clk       (clk),
      .reset     (resetB),
      .bus       (busB.slave),
      .load_en   (loadEnB),
      .load_addr (loadAddrB),
      .load_data (loadDataB),
      .rd_beats  (rdBeatsB),
      .wr_beats  (wrBeatsB),
      .err_cnt   (errCntB),
      .done_seen (doneSeenB)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Model helpers: address legality and word number from a byte address.
   function automatic bit isBad(input logic [63:0] a);
      return ((a >> (AW + 2)) != 64'd0) || (a[1:0] != 2'b00);
   endfunction

   function automatic int idxOf(input logic [63:0] a);
      return int'((a >> 2) & ((64'd1 << AW) - 64'd1));
   endfunction

   function automatic logic [31:0] refRead(input logic [63:0] a);
      if (isBad(a)) return BAD;
      if (refMem.exists(idxOf(a))) return refMem[idxOf(a)];
      return 32'hxxxxxxxx;
   endfunction

   function automatic logic [63:0] randOor(input int idx);
      if ($urandom_range(0, 1) == 0)
         return 64'(idx * 4) | 64'($urandom_range(1, 3));
      return (64'd1 << $urandom_range(AW + 2, 63)) | 64'(idx * 4);
   endfunction

   // Preload one word of instance A (must be idle).
   task automatic loadWord(input int idx, input logic [31:0] data);
      loadEnA   = 1'b1;
      loadAddrA = AW'(idx);
      loadDataA = data;
      @(posedge clk);
      @(negedge clk);
      loadEnA = 1'b0;
      refMem[idx] = data;
   endtask

   // One read beat on A: accept, wait for ready, check latency and data.
   // Starts and ends at a negedge; ends during the ready cycle.
   task automatic readBeat(input bit first, input logic [63:0] addr, input string tag);
      logic [31:0] exp;
      int lat;
      exp = refRead(addr);
      busA.read_enable = 1'b1;
      busA.read_addr   = addr;
      busA.finish_read = !first;
      @(posedge clk);
      @(negedge clk);
      busA.finish_read = 1'b0;
      busA.read_addr   = {$urandom, $urandom};
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (busA.read_ready != 64'd0) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat != A_RD_LAT) begin
         errors++;
         $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d", tag, lat, A_RD_LAT);
      end
      checks++;
      if (busA.read_ready !== 64'd1) begin
         errors++;
         $display("[TB] FAIL %s_ready_value: got %0h, expected 1", tag, busA.read_ready);
      end
      checks++;
      if (busA.read_data !== exp) begin
         errors++;
         $display("[TB] FAIL %s_data: addr %0h got %08h, expected %08h", tag, addr, busA.read_data, exp);
      end
      expRd++;
      if (isBad(addr)) expErr++;
   endtask

   // Close a read burst on A and confirm the ready pulse was one cycle wide.
   task automatic readEnd(input string tag);
      busA.read_enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busA.read_ready !== 64'd0) begin
         errors++;
         $display("[TB] FAIL %s_ready_width: got %0h after pulse, expected 0", tag, busA.read_ready);
      end
   endtask

   // One write beat on A: accept, wait for ready, hold the beat through the
   // ready cycle so it is committed, then check the pulse dropped.
   task automatic writeBeat(input bit first, input logic [63:0] addr, input logic [31:0] data,
                            input string tag);
      int lat;
      busA.write_enable = 1'b1;
      busA.write_addr   = addr;
      busA.write_data   = data;
      busA.finish_write = !first;
      @(posedge clk);
      @(negedge clk);
      busA.finish_write = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (busA.write_ready != 64'd0) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat != A_WR_LAT) begin
         errors++;
         $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d", tag, lat, A_WR_LAT);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busA.write_ready !== 64'd0) begin
         errors++;
         $display("[TB] FAIL %s_ready_width: got %0h after pulse, expected 0", tag, busA.write_ready);
      end
      expWr++;
      if (isBad(addr)) begin
         expErr++;
      end else begin
         refMem[idxOf(addr)] = data;
         written.push_back(idxOf(addr));
      end
   endtask

   task automatic writeEnd();
      busA.write_enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single-beat read burst on instance B with its longer latency.
   task automatic bReadBeat(input logic [63:0] addr, input logic [31:0] exp, input string tag);
      int lat;
      busB.read_enable = 1'b1;
      busB.read_addr   = addr;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (busB.read_ready != 64'd0) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat != B_RD_LAT) begin
         errors++;
         $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d", tag, lat, B_RD_LAT);
      end
      checks++;
      if (busB.read_data !== exp) begin
         errors++;
         $display("[TB] FAIL %s_data: got %08h, expected %08h", tag, busB.read_data, exp);
      end
      busB.read_enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] obs [7];
      string names [7];
      repeat (2) @(negedge clk);
      obs[0] = 32'(busA.read_ready);  names[0] = "rst_read_ready";
      obs[1] = 32'(busA.write_ready); names[1] = "rst_write_ready";
      obs[2] = busA.read_data;        names[2] = "rst_read_data";
      obs[3] = rdBeatsA;              names[3] = "rst_rd_beats";
      obs[4] = wrBeatsA;              names[4] = "rst_wr_beats";
      obs[5] = 32'(errCntA);          names[5] = "rst_err_cnt";
      obs[6] = 32'(doneSeenA);        names[6] = "rst_done_seen";
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (obs[i] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected 0", names[i], obs[i]);
         end
      end
      resetA = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_preload_read();
      logic [31:0] vals [4];
      vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30; vals[3] = 32'd40;
      for (int i = 0; i < 4; i++) loadWord(i, vals[i]);
      for (int i = 0; i < 4; i++) readBeat(i == 0, 64'(i * 4), "preload_rd");
      readEnd("preload_rd");
      checks++;
      if (rdBeatsA !== 32'd4) begin
         errors++;
         $display("[TB] FAIL preload_rd_beats: got %0d, expected 4", rdBeatsA);
      end
   endtask

   task automatic test_write_readback();
      for (int i = 0; i < 3; i++) writeBeat(i == 0, 64'h100 + 64'(i * 4), 32'(7 + i), "wb_wr");
      writeEnd();
      checks++;
      if (wrBeatsA !== 32'd3) begin
         errors++;
         $display("[TB] FAIL wb_wr_beats: got %0d, expected 3", wrBeatsA);
      end
      for (int i = 0; i < 3; i++) readBeat(i == 0, 64'h100 + 64'(i * 4), "wb_rd");
      readEnd("wb_rd");
   endtask

   task automatic test_out_of_range();
      readBeat(1'b1, 64'h2, "oor_misaligned");
      readBeat(1'b0, 64'h1_0000_0000, "oor_high");
      readEnd("oor_rd");
      checks++;
      if (errCntA !== 16'd2) begin
         errors++;
         $display("[TB] FAIL oor_err_after_reads: got %0d, expected 2", errCntA);
      end
      writeBeat(1'b1, 64'h1_0000_0000, 32'hBAD0BAD0, "oor_wr");
      writeEnd();
      checks++;
      if (errCntA !== 16'd3) begin
         errors++;
         $display("[TB] FAIL oor_err_after_write: got %0d, expected 3", errCntA);
      end
      readBeat(1'b1, 64'h0, "oor_word0_intact");
      readEnd("oor_word0_intact");
   endtask

   task automatic test_priority();
      int lat;
      busA.write_enable = 1'b1;
      busA.write_addr   = 64'h200;
      busA.write_data   = 32'h1234;
      readBeat(1'b1, 64'h4, "prio_rd");
      checks++;
      if (busA.write_ready !== 64'd0 || wrBeatsA !== 32'(expWr)) begin
         errors++;
         $display("[TB] FAIL prio_write_held: write_ready %0h wr_beats %0d, expected 0 and %0d",
                  busA.write_ready, wrBeatsA, expWr);
      end
      busA.read_enable = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (busA.write_ready != 64'd0) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat != 2 + A_WR_LAT) begin
         errors++;
         $display("[TB] FAIL prio_write_after_drop: got %0d cycles, expected %0d", lat, 2 + A_WR_LAT);
      end
      @(posedge clk);
      @(negedge clk);
      writeEnd();
      refMem[idxOf(64'h200)] = 32'h1234;
      expWr++;
      checks++;
      if (wrBeatsA !== 32'(expWr)) begin
         errors++;
         $display("[TB] FAIL prio_wr_beats: got %0d, expected %0d", wrBeatsA, expWr);
      end
      readBeat(1'b1, 64'h200, "prio_readback");
      readEnd("prio_readback");
   endtask

   task automatic test_done_and_load_guard();
      writeBeat(1'b1, 64'h300, 32'hA5A5_0001, "done_wr");
      busA.done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busA.done = 1'b0;
      checks++;
      if (doneSeenA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_seen_set: got %0b, expected 1", doneSeenA);
      end
      writeBeat(1'b0, 64'h304, 32'hA5A5_0002, "done_wr");
      writeEnd();
      repeat (5) @(negedge clk);
      checks++;
      if (doneSeenA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_seen_sticky: got %0b, expected 1", doneSeenA);
      end
      readBeat(1'b1, 64'h8, "guard_rd");
      loadEnA   = 1'b1;
      loadAddrA = AW'(2);
      loadDataA = 32'hFFFF_0000;
      @(posedge clk);
      @(negedge clk);
      loadEnA = 1'b0;
      readEnd("guard_rd");
      readBeat(1'b1, 64'h8, "guard_readback");
      readEnd("guard_readback");
   endtask

   task automatic test_random_traffic();
      for (int b = 0; b < 30; b++) begin
         int len;
         bit doWrite;
         logic [63:0] addr;
         len = $urandom_range(1, 4);
         if ($urandom_range(0, 5) == 0) loadWord(256 + $urandom_range(0, 255), $urandom);
         doWrite = (written.size() == 0) || ($urandom_range(0, 1) == 1);
         for (int k = 0; k < len; k++) begin
            if (doWrite) begin
               if ($urandom_range(0, 7) == 0) addr = randOor(256 + $urandom_range(0, 255));
               else addr = 64'((256 + $urandom_range(0, 255)) * 4);
               writeBeat(k == 0, addr, $urandom, "rnd_wr");
            end else begin
               if ($urandom_range(0, 7) == 0) addr = randOor(written[0]);
               else addr = 64'(written[$urandom_range(0, written.size() - 1)] * 4);
               readBeat(k == 0, addr, "rnd_rd");
            end
         end
         if (doWrite) writeEnd();
         else readEnd("rnd_rd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      checks++;
      if (rdBeatsA !== 32'(expRd) || wrBeatsA !== 32'(expWr) || errCntA !== 16'(expErr)) begin
         errors++;
         $display("[TB] FAIL rnd_counters: rd %0d wr %0d err %0d, expected %0d %0d %0d",
                  rdBeatsA, wrBeatsA, errCntA, expRd, expWr, expErr);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit sawPulse;
      resetB = 1'b1;
      @(negedge clk);
      loadEnB   = 1'b1;
      loadAddrB = AW'(5);
      loadDataB = 32'h55;
      @(posedge clk);
      @(negedge clk);
      loadEnB = 1'b0;
      bReadBeat(64'd20, 32'h55, "b_good");
      bReadBeat(64'd21, BAD, "b_bad");
      checks++;
      if (rdBeatsB !== 32'd2 || errCntB !== 16'd1) begin
         errors++;
         $display("[TB] FAIL b_pre_counters: rd %0d err %0d, expected 2 1", rdBeatsB, errCntB);
      end
      busB.read_enable = 1'b1;
      busB.read_addr   = 64'd20;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      resetB = 1'b0;
      busB.read_enable = 1'b0;
      #1;
      checks++;
      if (busB.read_ready !== 64'd0 || busB.read_data !== 32'd0) begin
         errors++;
         $display("[TB] FAIL b_reset_outputs: ready %0h data %08h, expected 0 0",
                  busB.read_ready, busB.read_data);
      end
      checks++;
      if (rdBeatsB !== 32'd0 || errCntB !== 16'd0) begin
         errors++;
         $display("[TB] FAIL b_reset_counters: rd %0d err %0d, expected 0 0", rdBeatsB, errCntB);
      end
      repeat (2) @(negedge clk);
      resetB = 1'b1;
      sawPulse = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (busB.read_ready != 64'd0) sawPulse = 1'b1;
      end
      checks++;
      if (sawPulse) begin
         errors++;
         $display("[TB] FAIL b_no_pulse_after_reset: got a read_ready pulse, expected none");
      end
      bReadBeat(64'd20, 32'h55, "b_after_reset");
      checks++;
      if (rdBeatsB !== 32'd1) begin
         errors++;
         $display("[TB] FAIL b_rd_beats_after_reset: got %0d, expected 1", rdBeatsB);
      end
   endtask

   task automatic test_final_reset();
      resetA = 1'b0;
      @(negedge clk);
      checks++;
      if (doneSeenA !== 1'b0 || rdBeatsA !== 32'd0 || wrBeatsA !== 32'd0 || errCntA !== 16'd0) begin
         errors++;
         $display("[TB] FAIL final_reset_state: done %0b rd %0d wr %0d err %0d, expected all 0",
                  doneSeenA, rdBeatsA, wrBeatsA, errCntA);
      end
      resetA = 1'b1;
      expRd  = 0;
      expWr  = 0;
      expErr = 0;
      @(negedge clk);
      readBeat(1'b1, 64'h0, "final_retained");
      readEnd("final_retained");
   endtask

   // Main sequence: initialise inputs, hold both instances in reset, then
   // run each scenario in turn and print the summary.
   initial begin
      busA.read_enable = 1'b0;  busA.read_addr = '0;  busA.finish_read = 1'b0;
      busA.write_enable = 1'b0; busA.write_addr = '0; busA.write_data = '0;
      busA.finish_write = 1'b0; busA.done = 1'b0;
      busB.read_enable = 1'b0;  busB.read_addr = '0;  busB.finish_read = 1'b0;
      busB.write_enable = 1'b0; busB.write_addr = '0; busB.write_data = '0;
      busB.finish_write = 1'b0; busB.done = 1'b0;
      loadEnA = 1'b0; loadAddrA = '0; loadDataA = '0;
      loadEnB = 1'b0; loadAddrB = '0; loadDataB = '0;
      #1;
      resetA = 1'b0;
      resetB = 1'b0;
      test_reset();
      test_preload_read();
      test_write_readback();
      test_out_of_range();
      test_priority();
      test_done_and_load_guard();
      test_random_traffic();
      test_reset_mid_burst();
      test_final_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/host_mem_responder.md
Name: host_mem_responder

Overview:
- Simulation/FPGA-side memory model that sits directly upstream of the kernel wrapper's host interface.
- Answers its word-by-word read handshake (read_enable / read_ready / finish_read) from an internal word array.
- Absorbs its write-back handshake (write_enable / write_ready / finish_write) into the same array.
- Has fixed, parameterised response latency, bounds checking and beat/error counters for the bench.

Parameters:
ADDR_WID, 14, word-index width; array depth is 2**ADDR_WID 32-bit words
RD_LAT, 2, cycles from accepted read request to read_ready pulse (legal range 1..15)
WR_LAT, 1, cycles from accepted write request to write_ready pulse (legal range 1..15)
BAD_DATA, 32'hDEADBEEF, read_data returned for out-of-range reads

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
read_enable  in  1  requester read burst active
read_addr  in  64  byte address of current read beat
finish_read  in  1  one-cycle pulse: previous beat consumed, read_addr now holds next beat
read_ready  out  64  value 1 for exactly one cycle per read beat, else 0
read_data  out  32  beat data, valid while read_ready==1
write_enable  in  1  requester write burst active
write_addr  in  64  byte address of current write beat
write_data  in  32  data of current write beat
finish_write  in  1  one-cycle pulse: next write beat presented
write_ready  out  64  value 1 for exactly one cycle per write beat, else 0
done  in  1  requester completion flag
load_en  in  1  bench preload strobe, honoured only in IDLE
load_addr  in  ADDR_WID  preload word index
load_data  in  32  preload data
rd_beats  out  32  read beats served since reset
wr_beats  out  32  write beats committed since reset
err_cnt  out  16  out-of-range accesses since reset (saturating)
done_seen  out  1  sticky: done observed high

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to IDLE.
  - read_ready, write_ready, read_data, rd_beats, wr_beats, err_cnt and done_seen all go to 0.
  - Array contents are NOT cleared.
  - Reset mid-burst abandons the burst; no ready pulse follows the release.
- Word index = addr[ADDR_WID+1:2]. An access is out of range if addr[63:ADDR_WID+2] != 0 or addr[1:0] != 0.
- States:
  - IDLE:
    - read_enable==1 → accept read, load latency counter, go RD_WAIT.
    - Else write_enable==1 → accept write, go WR_WAIT.
    - Read has priority when both are high; write stays pending.
    - load_en performs array[load_addr]<=load_data here only; it is ignored in all other states.
  - RD_WAIT: count down. At an accepted request sampled at edge k, the edge k+RD_LAT drives read_ready=1 and read_data from the array (or BAD_DATA if out of range, err_cnt+1). Address is latched at accept; later read_addr changes are ignored. Go RD_HOLD. rd_beats+1.
  - RD_HOLD: read_ready=0.
    - read_enable==0 → IDLE; this takes priority over finish_read.
    - Else finish_read==1 → accept new read_addr, go RD_WAIT.
    - Else stay.
  - WR_WAIT: at edge k+WR_LAT drive write_ready=1 for one cycle. Go WR_HOLD.
  - WR_HOLD: write_ready=0.
    - On the first cycle of this state, commit write_data to the array at write_addr. These are the values the requester holds while write_ready is high. Out of range → drop the write, err_cnt+1. wr_beats+1.
    - Then: write_enable==0 → IDLE; else finish_write==1 → WR_WAIT; else stay.
- A read_enable drop during RD_WAIT aborts the beat: no pulse, return to IDLE. Same rule for write_enable during WR_WAIT.
- read_data holds its last value outside pulses.
- done_seen is set on any cycle done==1 and is cleared only by reset.
- Counters: rd_beats and wr_beats wrap modulo 2^32; err_cnt saturates at 16'hFFFF.

Test Plan:
1. Preload words 0..3 = 10,20,30,40. Read burst at base 0 with step 4, 4 beats, finish_read pulsed after each pulse. Required: read_ready pulses 2 cycles after each accept; data 10,20,30,40; rd_beats=4.
2. Write burst of 3 beats to byte base 0x100, data 7,8,9, followed by a read-back burst. Required: write_ready 1 cycle after each accept; read-back returns 7,8,9; wr_beats=3.
3. Read at addr 0x2, then at 0x1_0000_0000. Required: read_data=DEADBEEF both times; err_cnt=2. Out-of-range write to 0x1_0000_0000 leaves the array unchanged; err_cnt=3.
4. read_enable and write_enable asserted in the same cycle from IDLE. Required: read served first. After read_enable drops, the write is accepted and committed.
5. Reset asserted during RD_WAIT (RD_LAT=4). Required: read_ready stays 0, counters go to 0, and a preloaded word is still readable after release.
6. Pulse done once mid-write. Required: done_seen=1 thereafter until reset. With load_en asserted during RD_HOLD, the array is not modified.
